// File: rtl/rr_mux_reg_pkg.sv
// rr_mux_reg_pkg: shared constants for the registered channel selector.
//   MODE_KEY / MODE_RR : encodings of the mode input.
//   state_t            : output register FSM state (EMPTY / FULL).
package rr_mux_reg_pkg;

  localparam logic MODE_KEY = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux_reg_pick.sv
// rr_pick: combinational rotating priority encoder.
//   req        : per-channel request vector
//   ptr        : channel with highest priority this cycle
//   gnt_onehot : one-hot grant (all zero when nothing requests)
//   gnt_idx    : index of the granted channel (0 when nothing requests)
//   any        : high when some channel was granted
// Search order is ptr, ptr+1, ..., NR_CH-1, 0, ..., ptr-1.
module rr_pick #(
  parameter int NR_CH   = 4,
  parameter int KEY_LEN = 2
) (
  input  logic [NR_CH-1:0]   req,
  input  logic [KEY_LEN-1:0] ptr,
  output logic [NR_CH-1:0]   gnt_onehot,
  output logic [KEY_LEN-1:0] gnt_idx,
  output logic               any
);

  always_comb begin
    int start;
    int idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    // The pointer never leaves 0..NR_CH-1, but an out-of-range value is
    // treated as 0 so the wrap arithmetic below stays within one subtraction.
    start = (int'(ptr) < NR_CH) ? int'(ptr) : 0;
    for (int i = 0; i < NR_CH; i++) begin
      idx = start + i;
      if (idx >= NR_CH) idx = idx - NR_CH;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = KEY_LEN'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NR_CH-to-1 selector with one output register stage.
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   mode       : 0 = key-select, 1 = round-robin
//   key        : channel index used in key-select mode
//   in_valid   : per-channel valid
//   in_data    : channel n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
//   in_ready   : one-hot grant; channel n transfers on in_valid[n] & in_ready[n]
//   out_valid  : output register holds a word
//   out_data   : registered word
//   out_ch     : channel that supplied out_data
//   out_ready  : consumer accepts on out_valid & out_ready
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready on the same side, ready (in_ready)
// may depend on out_ready, which lets a full register refill in the same
// cycle it is drained (no bubble at full throughput).
module rr_mux_reg
  import rr_mux_reg_pkg::*;
#(
  parameter int NR_CH    = 4,
  parameter int DATA_LEN = 2,
  parameter int KEY_LEN  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [KEY_LEN-1:0]        key,
  input  logic [NR_CH-1:0]          in_valid,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic [NR_CH-1:0]          in_ready,
  output logic                      out_valid,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [KEY_LEN-1:0]        out_ch,
  input  logic                      out_ready
);

  state_t              state_q, state_d;
  logic [KEY_LEN-1:0]  ptr_q;
  logic [DATA_LEN-1:0] data_q;
  logic [KEY_LEN-1:0]  ch_q;

  logic                can_load;
  logic [NR_CH-1:0]    key_onehot;
  logic [NR_CH-1:0]    rr_onehot;
  logic [KEY_LEN-1:0]  rr_idx;
  logic                rr_any;
  logic [NR_CH-1:0]    gnt;
  logic                gnt_any;
  logic [KEY_LEN-1:0]  gnt_idx;
  logic [DATA_LEN-1:0] sel_data;

  rr_pick #(
    .NR_CH   (NR_CH),
    .KEY_LEN (KEY_LEN)
  ) u_pick (
    .req        (in_valid),
    .ptr        (ptr_q),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .any        (rr_any)
  );

  // An out-of-range key matches no channel, so it simply produces no grant.
  always_comb begin
    key_onehot = '0;
    for (int n = 0; n < NR_CH; n++) begin
      if (int'(key) == n && in_valid[n]) key_onehot[n] = 1'b1;
    end
  end

  assign can_load = (state_q == ST_EMPTY) || out_ready;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (!rst && can_load) begin
      if (mode == MODE_RR) begin
        gnt     = rr_onehot;
        gnt_idx = rr_idx;
      end else begin
        gnt     = key_onehot;
        gnt_idx = key;
      end
    end
  end

  assign gnt_any  = |gnt;
  assign in_ready = gnt;

  // One-hot AND-OR mux driven by the grant, so in_data only reaches the
  // output through the register.
  always_comb begin
    sel_data = '0;
    for (int n = 0; n < NR_CH; n++) begin
      if (gnt[n]) sel_data = sel_data | in_data[n*DATA_LEN +: DATA_LEN];
    end
  end

  // Next-state logic for the output register FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (gnt_any) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !gnt_any) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ch_q   <= '0;
    end else if (gnt_any) begin
      data_q <= sel_data;
      ch_q   <= gnt_idx;
    end
  end

  // The pointer moves past the winner only on round-robin grants, so
  // key-select traffic never disturbs round-robin fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt_any && mode == MODE_RR) begin
      ptr_q <= (rr_idx == KEY_LEN'(NR_CH - 1)) ? '0 : rr_idx + KEY_LEN'(1);
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
module tb_rr_mux_reg;

  localparam int NR_CH    = 4;
  localparam int DATA_LEN = 2;
  localparam int KEY_LEN  = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      mode;
  logic [KEY_LEN-1:0]        key;
  logic [NR_CH-1:0]          in_valid;
  logic [NR_CH*DATA_LEN-1:0] in_data;
  logic [NR_CH-1:0]          in_ready;
  logic                      out_valid;
  logic [DATA_LEN-1:0]       out_data;
  logic [KEY_LEN-1:0]        out_ch;
  logic                      out_ready;

  rr_mux_reg #(
    .NR_CH    (NR_CH),
    .DATA_LEN (DATA_LEN),
    .KEY_LEN  (KEY_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .key       (key),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  // vector: inputs for one cycle, expected in_ready during that cycle and
  // expected registered outputs after the following rising edge
  typedef struct {
    logic                rst;
    logic                mode;
    logic [KEY_LEN-1:0]  key;
    logic [NR_CH-1:0]    vld;
    logic                ordy;
    logic [NR_CH-1:0]    exp_rdy;
    logic                exp_ov;
    logic [DATA_LEN-1:0] exp_od;
    logic [KEY_LEN-1:0]  exp_och;
  } vec_t;

  vec_t vq[$];

  int total = 0;
  int bad   = 0;

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic [KEY_LEN-1:0] k,
                     input logic [NR_CH-1:0] v, input logic o,
                     input logic [NR_CH-1:0] er, input logic eov,
                     input logic [DATA_LEN-1:0] eod, input logic [KEY_LEN-1:0] eoch);
    vec_t t;
    t.rst = r; t.mode = m; t.key = k; t.vld = v; t.ordy = o;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_och = eoch;
    vq.push_back(t);
  endtask

  // driver: apply one cycle, check ready mid-cycle, outputs after the edge
  task automatic step(input string tag, input vec_t t);
    rst = t.rst; mode = t.mode; key = t.key; in_valid = t.vld; out_ready = t.ordy;
    #3;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(t.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(t.exp_ov));
    chk({tag, " out_data"},  32'(out_data),  32'(t.exp_od));
    chk({tag, " out_ch"},    32'(out_ch),    32'(t.exp_och));
  endtask

  initial begin
    vec_t t;
    rst = 1'b1; mode = 1'b0; key = '0; in_valid = '0; out_ready = 1'b0;
    in_data = {2'd3, 2'd2, 2'd1, 2'd0};

    //   rst mode key vld      ordy rdy      ov od   och
    // reset with everything requesting
    add(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 2'd0, 2'd0);
    add(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 2'd0, 2'd0);
    // round-robin fairness 0,1,2,3,0,1
    add(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 2'd0, 2'd0);
    add(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 2'd1, 2'd1);
    add(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2'd2, 2'd2);
    add(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 2'd3, 2'd3);
    add(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 2'd0, 2'd0);
    add(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 2'd1, 2'd1);
    // key-select key=2 (ptr left at 2)
    add(0, 0, 2, 4'b1111, 1, 4'b0100, 1, 2'd2, 2'd2);
    add(0, 0, 2, 4'b1111, 1, 4'b0100, 1, 2'd2, 2'd2);
    add(0, 0, 2, 4'b1111, 1, 4'b0100, 1, 2'd2, 2'd2);
    // key miss: drains, stays empty, then ch1 raised
    add(0, 0, 1, 4'b1101, 1, 4'b0000, 0, 2'd2, 2'd2);
    add(0, 0, 1, 4'b1101, 1, 4'b0000, 0, 2'd2, 2'd2);
    add(0, 0, 1, 4'b1111, 1, 4'b0010, 1, 2'd1, 2'd1);
    // rr grant to ch2 moves ptr to 3, then sparse 1001 wraps 3,0,3,0
    add(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 2'd2, 2'd2);
    add(0, 1, 0, 4'b1001, 1, 4'b1000, 1, 2'd3, 2'd3);
    add(0, 1, 0, 4'b1001, 1, 4'b0001, 1, 2'd0, 2'd0);
    add(0, 1, 0, 4'b1001, 1, 4'b1000, 1, 2'd3, 2'd3);
    add(0, 1, 0, 4'b1001, 1, 4'b0001, 1, 2'd0, 2'd0);
    // backpressure: load ch1, stall 3 cycles (key change mid-stall), release to ch2
    add(0, 0, 1, 4'b1111, 1, 4'b0010, 1, 2'd1, 2'd1);
    add(0, 0, 1, 4'b1111, 0, 4'b0000, 1, 2'd1, 2'd1);
    add(0, 0, 3, 4'b1111, 0, 4'b0000, 1, 2'd1, 2'd1);
    add(0, 1, 2, 4'b1111, 0, 4'b0000, 1, 2'd1, 2'd1);
    add(0, 0, 2, 4'b0100, 1, 4'b0100, 1, 2'd2, 2'd2);
    // mid-transfer reset discards the word and clears ptr
    add(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 2'd0, 2'd0);
    add(0, 1, 0, 4'b1010, 0, 4'b0010, 1, 2'd1, 2'd1);
    add(0, 1, 0, 4'b1010, 0, 4'b0000, 1, 2'd1, 2'd1);
    add(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 2'd1, 2'd1);

    foreach (vq[i]) begin
      t = vq[i];
      step($sformatf("v%0d", i), t);
    end

    // hand sequence: distinct channel data, then in_data changed during a
    // stall must not reach the held word
    in_data = {2'd0, 2'd1, 2'd2, 2'd3};
    t = '{rst: 0, mode: 0, key: 0, vld: 4'b0001, ordy: 1,
          exp_rdy: 4'b0001, exp_ov: 1, exp_od: 2'd3, exp_och: 2'd0};
    step("h_load", t);
    t = '{rst: 0, mode: 0, key: 0, vld: 4'b0001, ordy: 0,
          exp_rdy: 4'b0000, exp_ov: 1, exp_od: 2'd3, exp_och: 2'd0};
    in_data = {2'd2, 2'd2, 2'd2, 2'd1};
    step("h_stall", t);
    // release: rr mode, ptr is 2 after the reset sequence -> search 2,3,0: ch3
    t = '{rst: 0, mode: 1, key: 0, vld: 4'b1001, ordy: 1,
          exp_rdy: 4'b1000, exp_ov: 1, exp_od: 2'd2, exp_och: 2'd3};
    step("h_rr", t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard bound so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
